// File: rtl/inst_fetch_queue_pkg.sv
// rtl/inst_fetch_queue_pkg.sv - shared states and fetch-width constants for the fetch queue
package inst_fetch_queue_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_FLUSH = 2'd2
  } if_state_e;

  localparam int FETCH_WIDTH = 4;
  localparam int FETCH_BYTES = 4 * FETCH_WIDTH;

endpackage

// File: rtl/fetch_queue_ram.sv
// rtl/fetch_queue_ram.sv - circular instruction storage, 4-wide write and one async read port
module fetch_queue_ram
  import inst_fetch_queue_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          wr_en_i,
  input  logic [PW-1:0]                 wr_ptr_i,
  input  logic [FETCH_WIDTH*DATA_W-1:0] wr_data_i,
  input  logic [PW-1:0]                 rd_ptr_i,
  output logic [DATA_W-1:0]             rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Slot index wraps naturally in PW bits, so a burst can straddle the end of the ring.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        mem_q[wr_ptr_i + PW'(k)] <= wr_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign rd_data_o = mem_q[rd_ptr_i];

endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - fetch request FSM, instruction queue and decode handshake
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 8,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              InstMem_Read,
  output logic [DATA_W-1:0] inst_address,
  input  logic [DATA_W-1:0] inst1_in,
  input  logic [DATA_W-1:0] inst2_in,
  input  logic [DATA_W-1:0] inst3_in,
  input  logic [DATA_W-1:0] inst4_in,
  input  logic              InstMem_Ready,
  input  logic              redirect,
  input  logic [DATA_W-1:0] redirect_pc,
  input  logic              dec_ready,
  output logic              dec_valid,
  output logic [DATA_W-1:0] dec_inst,
  output logic [DATA_W-1:0] dec_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if_state_e         state_q;
  logic [DATA_W-1:0] fetch_pc_q;
  logic [DATA_W-1:0] head_pc_q;
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic [31:0]       free;
  logic              wr_fire;
  logic              pop;
  logic [DATA_W-1:0] rd_data;

  // A redirect in the same cycle discards both the memory response and the pop.
  assign free    = 32'(DEPTH) - 32'(count_q);
  assign wr_fire = (state_q == S_REQ) && InstMem_Ready && !redirect;
  assign pop     = dec_valid && dec_ready && !redirect;
  assign count_d = count_q + (wr_fire ? CW'(FETCH_WIDTH) : '0) - (pop ? CW'(1) : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      head_pc_q  <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else if (redirect) begin
      state_q    <= S_FLUSH;
      fetch_pc_q <= redirect_pc;
      head_pc_q  <= redirect_pc;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      count_q <= count_d;
      if (wr_fire) begin
        wr_ptr_q   <= wr_ptr_q + PW'(FETCH_WIDTH);
        fetch_pc_q <= fetch_pc_q + DATA_W'(FETCH_BYTES);
      end
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + PW'(1);
        head_pc_q <= head_pc_q + DATA_W'(4);
      end
      // Room is judged on the registered count; a pop this cycle earns no credit.
      case (state_q)
        S_IDLE:  if (free >= 32'(FETCH_WIDTH)) state_q <= S_REQ;
        S_REQ:   if (InstMem_Ready) state_q <= (free >= 32'(2*FETCH_WIDTH)) ? S_REQ : S_IDLE;
        S_FLUSH: state_q <= S_REQ;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  fetch_queue_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (wr_fire),
    .wr_ptr_i  (wr_ptr_q),
    .wr_data_i ({inst4_in, inst3_in, inst2_in, inst1_in}),
    .rd_ptr_i  (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  assign InstMem_Read = (state_q == S_REQ);
  assign inst_address = fetch_pc_q;
  assign dec_valid    = (count_q != '0);
  assign dec_inst     = dec_valid ? rd_data : '0;
  assign dec_pc       = head_pc_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - scoreboard bench for inst_fetch_queue
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        InstMem_Read;
  logic [31:0] inst_address;
  logic [31:0] inst1_in, inst2_in, inst3_in, inst4_in;
  logic        InstMem_Ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;

  logic [31:0] prog [4096];
  logic [63:0] exp_q [$];
  logic [31:0] next_pc;
  int          n_pass = 0;
  int          n_total = 0;
  int          n_pops = 0;

  inst_fetch_queue #(.DATA_W(32), .DEPTH(8), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .InstMem_Read  (InstMem_Read),
    .inst_address  (inst_address),
    .inst1_in      (inst1_in),
    .inst2_in      (inst2_in),
    .inst3_in      (inst3_in),
    .inst4_in      (inst4_in),
    .InstMem_Ready (InstMem_Ready),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .dec_ready     (dec_ready),
    .dec_valid     (dec_valid),
    .dec_inst      (dec_inst),
    .dec_pc        (dec_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic refill();
    while (exp_q.size() < 64) begin
      exp_q.push_back({next_pc, prog[next_pc[13:2]]});
      next_pc = next_pc + 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] pc);
    exp_q.delete();
    next_pc = pc;
    refill();
  endtask

  // Memory model: four consecutive words around the current request address.
  always @(negedge clk) begin
    logic [31:0] a1, a2, a3;
    a1 = inst_address + 32'd4;
    a2 = inst_address + 32'd8;
    a3 = inst_address + 32'd12;
    inst1_in = prog[inst_address[13:2]];
    inst2_in = prog[a1[13:2]];
    inst3_in = prog[a2[13:2]];
    inst4_in = prog[a3[13:2]];
  end

  // Scoreboard monitor: every accepted instruction is compared with the head of the expected stream.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst && dec_valid && dec_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("dec_pc", dec_pc, e[63:32]);
        check("dec_inst", dec_inst, e[31:0]);
      end
      n_pops++;
    end
  end

  initial begin
    int pops_start;
    int cyc;
    for (int i = 0; i < 4096; i++) prog[i] = $urandom;
    rst = 1'b1; InstMem_Ready = 1'b0; redirect = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
    inst1_in = '0; inst2_in = '0; inst3_in = '0; inst4_in = '0;
    restart(32'h0);

    #12;
    check("rst_read", 32'(InstMem_Read), 32'd0);
    check("rst_valid", 32'(dec_valid), 32'd0);
    check("rst_addr", inst_address, 32'h0);
    check("rst_pc", dec_pc, 32'h0);
    check("rst_inst", dec_inst, 32'h0);

    step();
    rst = 1'b0;
    check("idle_after_release", 32'(InstMem_Read), 32'd0);
    step();
    check("first_read", 32'(InstMem_Read), 32'd1);
    check("first_addr", inst_address, 32'h0);

    // Three wait states: request held, nothing written.
    for (int i = 0; i < 3; i++) begin
      step();
      check("wait_read", 32'(InstMem_Read), 32'd1);
      check("wait_addr", inst_address, 32'h0);
      check("wait_valid", 32'(dec_valid), 32'd0);
    end
    InstMem_Ready = 1'b1;

    step();
    check("fill1_valid", 32'(dec_valid), 32'd1);
    check("fill1_pc", dec_pc, 32'h0);
    check("fill1_inst", dec_inst, prog[0]);
    check("fill2_read", 32'(InstMem_Read), 32'd1);
    check("fill2_addr", inst_address, 32'h10);
    for (int i = 0; i < 3; i++) begin
      step();
      check("full_read", 32'(InstMem_Read), 32'd0);
      check("full_pc", dec_pc, 32'h0);
      check("full_inst", dec_inst, prog[0]);
    end

    dec_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      refill();
      check("stream_no_gap", 32'(dec_valid), 32'd1);
    end

    for (int i = 0; i < 20 && !InstMem_Read; i++) begin
      step();
      refill();
    end
    check("redir_pre_read", 32'(InstMem_Read), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h100; dec_ready = 1'b0;
    restart(32'h100);
    step();
    redirect = 1'b0;
    check("redir_valid_drop", 32'(dec_valid), 32'd0);
    check("redir_flush_read", 32'(InstMem_Read), 32'd0);
    step();
    check("redir_read", 32'(InstMem_Read), 32'd1);
    check("redir_addr", inst_address, 32'h100);
    check("redir_valid_wait", 32'(dec_valid), 32'd0);
    step();
    check("redir_valid", 32'(dec_valid), 32'd1);
    check("redir_pc", dec_pc, 32'h100);
    check("redir_inst", dec_inst, prog[32'h40]);

    // Address wrap, then a long random program with stalls and occasional redirects.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF0;
    restart(32'hFFFF_FFF0);
    step();
    redirect = 1'b0;
    pops_start = n_pops;
    cyc = 0;
    while (cyc < 80000 && (n_pops - pops_start) < 20000) begin
      step();
      cyc++;
      InstMem_Ready = ($urandom_range(0, 3) != 0);
      dec_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 999) == 0) begin
        redirect = 1'b1;
        redirect_pc = {18'h0, 12'($urandom_range(0, 4095)), 2'b00};
        restart(redirect_pc);
      end else begin
        redirect = 1'b0;
        refill();
      end
    end
    redirect = 1'b0;
    check("random_pop_budget", 32'((n_pops - pops_start) >= 20000), 32'd1);

    // Reset in the middle of a request drops the read at once.
    InstMem_Ready = 1'b0;
    dec_ready = 1'b1;
    for (int i = 0; i < 20 && !InstMem_Read; i++) begin
      step();
      refill();
    end
    check("midreq_read", 32'(InstMem_Read), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_read", 32'(InstMem_Read), 32'd0);
    check("async_rst_valid", 32'(dec_valid), 32'd0);
    check("async_rst_addr", inst_address, 32'h0);
    restart(32'h0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
